// File: rtl/preset_entry_pkg.sv
// Shared definitions for the preset entry stage: FSM encoding, default sizing
// and the shortened hold/repeat periods used in simulation.
package preset_entry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam int VAL_W_DEFAULT         = 6;
    localparam int MAX_VAL_DEFAULT       = 63;
    localparam int HOLD_CYCLES_DEFAULT   = 50_000_000;
    localparam int REPEAT_CYCLES_DEFAULT = 10_000_000;

    localparam int SIM_HOLD_CYCLES   = 8;
    localparam int SIM_REPEAT_CYCLES = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/preset_entry_rise_pulse.sv
// Rising-edge detector for one debounced level: a history flop plus an AND.
// The history flop tracks the input even during reset, so a button that is
// already held when reset releases never looks like a fresh press.
module preset_entry_rise_pulse (
    input  logic clk,
    input  logic level,
    output logic rise
);

    logic level_q_reg;

    always_ff @(posedge clk) begin
        level_q_reg <= level;
    end

    assign rise = level & ~level_q_reg;

endmodule

// File: rtl/preset_entry.sv
// Button-driven preset editor: wrap-around up/down stepping with
// hold-to-auto-repeat, clear, and a commit that publishes the value + strobe.
module preset_entry
    import preset_entry_pkg::*;
#(
    parameter int VAL_W         = VAL_W_DEFAULT,
    parameter int MAX_VAL       = MAX_VAL_DEFAULT,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic             clear,
    input  logic             commit,
    output logic [VAL_W-1:0] preset,
    output logic [VAL_W-1:0] committed,
    output logic             commit_pulse,
    output logic             repeating
);

    localparam int TIMER_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
    localparam logic [VAL_W-1:0]   MAX_V       = VAL_W'(MAX_VAL);

    // Bit order: 0 up, 1 down, 2 clear, 3 commit
    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic       up_rise, down_rise, clear_rise, commit_rise;

    assign btn_level = {commit, clear, down, up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rise
            preset_entry_rise_pulse u_rise (
                .clk   (clk),
                .level (btn_level[gi]),
                .rise  (btn_rise[gi])
            );
        end
    endgenerate

    assign up_rise     = btn_rise[0];
    assign down_rise   = btn_rise[1];
    assign clear_rise  = btn_rise[2];
    assign commit_rise = btn_rise[3];

    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               dir_up_reg, dir_up_next;
    logic [VAL_W-1:0]   preset_reg, preset_next;
    logic [VAL_W-1:0]   committed_reg;
    logic               commit_pulse_reg;
    logic               repeating_reg;

    logic held;
    logic start;
    logic step;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        dir_up_next = dir_up_reg;
        preset_next = preset_reg;
        held        = dir_up_reg ? up : down;
        start       = 1'b0;
        step        = 1'b0;

        if (up && down) begin
            state_next = ST_IDLE;
            timer_next = '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (!held) begin
                        start = 1'b1;
                    end else if (timer_reg == HOLD_LAST) begin
                        step       = 1'b1;
                        timer_next = '0;
                        state_next = ST_REPEAT;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!held) begin
                        start = 1'b1;
                    end else if (timer_reg == REPEAT_LAST) begin
                        step       = 1'b1;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                default: start = 1'b1;
            endcase

            // Released (or idle): fall back to IDLE, but a fresh press on
            // either button in this same cycle still starts a new step.
            if (start) begin
                state_next = ST_IDLE;
                timer_next = '0;
                if (up_rise || down_rise) begin
                    step        = 1'b1;
                    dir_up_next = up_rise;
                    state_next  = ST_HOLD;
                end
            end
        end

        if (clear_rise) begin
            state_next  = ST_IDLE;
            timer_next  = '0;
            preset_next = '0;
        end else if (step) begin
            if (dir_up_next) begin
                preset_next = (preset_reg == MAX_V) ? '0 : preset_reg + 1'b1;
            end else begin
                preset_next = (preset_reg == '0) ? MAX_V : preset_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            timer_reg        <= '0;
            dir_up_reg       <= 1'b0;
            preset_reg       <= '0;
            committed_reg    <= '0;
            commit_pulse_reg <= 1'b0;
            repeating_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            dir_up_reg       <= dir_up_next;
            preset_reg       <= preset_next;
            commit_pulse_reg <= commit_rise;
            repeating_reg    <= (state_next == ST_REPEAT);
            if (commit_rise) begin
                committed_reg <= preset_reg;
            end
        end
    end

    assign preset       = preset_reg;
    assign committed    = committed_reg;
    assign commit_pulse = commit_pulse_reg;
    assign repeating    = repeating_reg;

endmodule

// File: tb/tb_preset_entry.sv
// Scoreboard bench for preset_entry with short hold/repeat periods: each
// driven cycle queues its expected outputs, checked right after the edge.
module tb_preset_entry;
    import preset_entry_pkg::*;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       up     = 1'b0;
    logic       down   = 1'b0;
    logic       clear  = 1'b0;
    logic       commit = 1'b0;
    logic [5:0] preset;
    logic [5:0] committed;
    logic       commit_pulse;
    logic       repeating;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      tag;
        logic [5:0] pre;
        logic [5:0] com;
        logic       pulse;
        logic       rep;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    preset_entry #(
        .VAL_W         (6),
        .MAX_VAL       (63),
        .HOLD_CYCLES   (SIM_HOLD_CYCLES),
        .REPEAT_CYCLES (SIM_REPEAT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .up           (up),
        .down         (down),
        .clear        (clear),
        .commit       (commit),
        .preset       (preset),
        .committed    (committed),
        .commit_pulse (commit_pulse),
        .repeating    (repeating)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, queue expectation, check after posedge.
    task automatic cyc(input logic rst_n, input logic u, input logic d,
                       input logic cl, input logic cm, input string tag,
                       input int ep, input int ec, input logic epl, input logic er);
        exp_t e;
        @(negedge clk);
        reset  = rst_n;
        up     = u;
        down   = d;
        clear  = cl;
        commit = cm;
        e.tag   = tag;
        e.pre   = 6'(ep);
        e.com   = 6'(ec);
        e.pulse = epl;
        e.rep   = er;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, ".preset"},    {2'b00, preset},       {2'b00, e.pre});
        check_eq({e.tag, ".committed"}, {2'b00, committed},    {2'b00, e.com});
        check_eq({e.tag, ".pulse"},     {7'd0, commit_pulse},  {7'd0, e.pulse});
        check_eq({e.tag, ".repeating"}, {7'd0, repeating},     {7'd0, e.rep});
        $display("[TB] %s rst=%b u=%b d=%b cl=%b cm=%b -> preset=%0d committed=%0d pulse=%b rep=%b",
                 tag, rst_n, u, d, cl, cm, preset, committed, commit_pulse, repeating);
    endtask

    initial begin
        // 1: reset with up held; no step until up toggles low->high
        cyc(0, 1, 0, 0, 0, "rst0", 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, "rst1", 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "rel_held0", 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "rel_held1", 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "rel_held2", 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "up_low", 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "up_rise", 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "up_rel", 1, 0, 0, 0);

        // 2: wrap both ways
        cyc(1, 0, 1, 0, 0, "dn_to0", 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "idle_a", 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, "dn_wrap", 63, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "idle_b", 63, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "up_wrap", 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "idle_c", 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, "dn_wrap2", 63, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "idle_d", 63, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, "clear", 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "idle_e", 0, 0, 0, 0);

        // 3: hold up 20 cycles: steps at 0, +8, +11, +14, +17
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1, 0, 0, 0, $sformatf("hold%0d", k),
                1 + int'(k >= 8) + int'(k >= 11) + int'(k >= 14) + int'(k >= 17),
                0, 0, (k >= 8));
        end
        cyc(1, 0, 0, 0, 0, "hold_rel", 5, 0, 0, 0);

        // 4: simultaneous up/down
        cyc(1, 1, 1, 0, 0, "both0", 5, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, "both1", 5, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cyc(1, 1, 0, 0, 0, $sformatf("up_only%0d", k), 5, 0, 0, 0);
        end
        cyc(1, 0, 0, 0, 0, "both_rel", 5, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "repress", 6, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, "repress_rel", 6, 0, 0, 0);

        // 5: step to 12, then commit behaviour
        for (int k = 0; k < 6; k++) begin
            cyc(1, 1, 0, 0, 0, $sformatf("inc%0d", k), 7 + k, 0, 0, 0);
            cyc(1, 0, 0, 0, 0, $sformatf("inc_rel%0d", k), 7 + k, 0, 0, 0);
        end
        cyc(1, 0, 0, 0, 1, "commit_rise", 12, 12, 1, 0);
        for (int k = 0; k < 9; k++) begin
            cyc(1, 0, 0, 0, 1, $sformatf("commit_hold%0d", k), 12, 12, 0, 0);
        end
        cyc(1, 0, 0, 0, 0, "commit_rel", 12, 12, 0, 0);
        cyc(1, 0, 0, 1, 1, "commit_clear", 0, 12, 1, 0);
        cyc(1, 0, 0, 0, 0, "cc_rel", 0, 12, 0, 0);
        cyc(1, 1, 0, 0, 1, "commit_step", 1, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, "cs_rel", 1, 0, 0, 0);

        // 6: auto-repeat up to 40, then reset mid-repeat with up still held
        for (int k = 0; k < 120; k++) begin
            cyc(1, 1, 0, 0, 0, $sformatf("run%0d", k),
                (k < 8) ? 2 : 3 + (k - 8) / 3, 0, 0, (k >= 8));
        end
        cyc(0, 1, 0, 0, 0, "mid_rst", 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cyc(1, 1, 0, 0, 0, $sformatf("post_rst%0d", k), 0, 0, 0, 0);
        end
        cyc(1, 0, 0, 0, 0, "post_rel", 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, "post_press", 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
